// File: rtl/id_ex_stage_pkg.sv
`default_nettype none
// id_ex_stage_pkg: widths, register-zero constant and control bundle shared by the ID/EX pipeline slice.
package id_ex_stage_pkg;

  localparam int ALUOP_W = 4;
  localparam int REG_W   = 5;
  localparam int DATA_W  = 32;
  localparam int CNT_W   = 16;

  localparam logic [REG_W-1:0] REG_ZERO  = 5'd0;
  localparam logic [CNT_W-1:0] CNT_MAX   = 16'hFFFF;

  typedef struct packed {
    logic               reg_dst;
    logic               alu_src;
    logic               mem_read;
    logic               mem_write;
    logic               mem_to_reg;
    logic               reg_write;
    logic [ALUOP_W-1:0] alu_op;
  } ctrl_t;

  // Saturating increment; returns the count unchanged when not enabled.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] count, input logic en);
    sat_inc = (en && count != CNT_MAX) ? count + 16'd1 : count;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_detect.sv
`default_nettype none
// hazard_detect: combinational load-use detector between the ID/EX register and the ID stage.
module hazard_detect
  import id_ex_stage_pkg::*;
(
  input  logic             rst,
  input  logic             flush,
  input  logic             ex_valid,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  output logic             stall
);

  logic load_use;

  assign load_use = ex_valid && ex_mem_read && (ex_rt != REG_ZERO) && id_valid &&
                    ((ex_rt == id_rs) || (ex_rt == id_rt));

  // A redirect discards the consumer, and reset leaves no stall behind.
  assign stall = load_use && !flush && !rst;

endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// id_ex_stage: ID/EX pipeline register with load-use bubble insertion and a saturating stall counter.
module id_ex_stage
  import id_ex_stage_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               ID_Valid,
  input  logic [REG_W-1:0]   ID_RegRs,
  input  logic [REG_W-1:0]   ID_RegRt,
  input  logic [REG_W-1:0]   ID_RegRd,
  input  logic [DATA_W-1:0]  ID_ReadData1,
  input  logic [DATA_W-1:0]  ID_ReadData2,
  input  logic [DATA_W-1:0]  ID_Imm,
  input  logic               ID_RegDst,
  input  logic               ID_ALUSrc,
  input  logic               ID_MemRead,
  input  logic               ID_MemWrite,
  input  logic               ID_MemtoReg,
  input  logic               ID_RegWrite,
  input  logic [ALUOP_W-1:0] ID_ALUOp,
  input  logic               Flush,
  output logic               IDEX_Valid,
  output logic [REG_W-1:0]   IDEX_RegRs,
  output logic [REG_W-1:0]   IDEX_RegRt,
  output logic [REG_W-1:0]   IDEX_RegRd,
  output logic [DATA_W-1:0]  IDEX_ReadData1,
  output logic [DATA_W-1:0]  IDEX_ReadData2,
  output logic [DATA_W-1:0]  IDEX_Imm,
  output logic               IDEX_RegDst,
  output logic               IDEX_ALUSrc,
  output logic               IDEX_MemRead,
  output logic               IDEX_MemWrite,
  output logic               IDEX_MemtoReg,
  output logic               IDEX_RegWrite,
  output logic [ALUOP_W-1:0] IDEX_ALUOp,
  output logic               Stall,
  output logic [CNT_W-1:0]   StallCount
);

  ctrl_t id_ctrl;
  ctrl_t ex_ctrl;
  logic  bubble;

  assign id_ctrl = '{reg_dst: ID_RegDst, alu_src: ID_ALUSrc, mem_read: ID_MemRead,
                     mem_write: ID_MemWrite, mem_to_reg: ID_MemtoReg,
                     reg_write: ID_RegWrite, alu_op: ID_ALUOp};

  hazard_detect u_hazard_detect (
    .rst         (rst),
    .flush       (Flush),
    .ex_valid    (IDEX_Valid),
    .ex_mem_read (ex_ctrl.mem_read),
    .ex_rt       (IDEX_RegRt),
    .id_valid    (ID_Valid),
    .id_rs       (ID_RegRs),
    .id_rt       (ID_RegRt),
    .stall       (Stall)
  );

  // Bubbles zero every field so their register numbers never match a forwarding producer.
  assign bubble = Stall || Flush || !ID_Valid;

  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      IDEX_Valid     <= 1'b0;
      IDEX_RegRs     <= '0;
      IDEX_RegRt     <= '0;
      IDEX_RegRd     <= '0;
      IDEX_ReadData1 <= '0;
      IDEX_ReadData2 <= '0;
      IDEX_Imm       <= '0;
      ex_ctrl        <= '0;
    end else begin
      IDEX_Valid     <= 1'b1;
      IDEX_RegRs     <= ID_RegRs;
      IDEX_RegRt     <= ID_RegRt;
      IDEX_RegRd     <= ID_RegRd;
      IDEX_ReadData1 <= ID_ReadData1;
      IDEX_ReadData2 <= ID_ReadData2;
      IDEX_Imm       <= ID_Imm;
      ex_ctrl        <= id_ctrl;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      StallCount <= '0;
    end else begin
      StallCount <= sat_inc(StallCount, Stall);
    end
  end

  assign IDEX_RegDst   = ex_ctrl.reg_dst;
  assign IDEX_ALUSrc   = ex_ctrl.alu_src;
  assign IDEX_MemRead  = ex_ctrl.mem_read;
  assign IDEX_MemWrite = ex_ctrl.mem_write;
  assign IDEX_MemtoReg = ex_ctrl.mem_to_reg;
  assign IDEX_RegWrite = ex_ctrl.reg_write;
  assign IDEX_ALUOp    = ex_ctrl.alu_op;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// tb_id_ex_stage: directed load-use scenarios plus randomized traffic against a behavioural pipeline-register model.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ID_Valid;
  logic [4:0]  ID_RegRs, ID_RegRt, ID_RegRd;
  logic [31:0] ID_ReadData1, ID_ReadData2, ID_Imm;
  logic        ID_RegDst, ID_ALUSrc, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_RegWrite;
  logic [3:0]  ID_ALUOp;
  logic        Flush;
  logic        IDEX_Valid;
  logic [4:0]  IDEX_RegRs, IDEX_RegRt, IDEX_RegRd;
  logic [31:0] IDEX_ReadData1, IDEX_ReadData2, IDEX_Imm;
  logic        IDEX_RegDst, IDEX_ALUSrc, IDEX_MemRead, IDEX_MemWrite, IDEX_MemtoReg, IDEX_RegWrite;
  logic [3:0]  IDEX_ALUOp;
  logic        Stall;
  logic [15:0] StallCount;

  int total = 0;
  int bad   = 0;

  // Reference state: what the ID/EX register should hold after each edge.
  logic        m_valid;
  logic [4:0]  m_rs, m_rt, m_rd;
  logic [31:0] m_d1, m_d2, m_imm;
  logic [9:0]  m_ctrl;
  logic [15:0] m_cnt;
  logic        m_stall;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .ID_Valid(ID_Valid),
    .ID_RegRs(ID_RegRs), .ID_RegRt(ID_RegRt), .ID_RegRd(ID_RegRd),
    .ID_ReadData1(ID_ReadData1), .ID_ReadData2(ID_ReadData2), .ID_Imm(ID_Imm),
    .ID_RegDst(ID_RegDst), .ID_ALUSrc(ID_ALUSrc), .ID_MemRead(ID_MemRead),
    .ID_MemWrite(ID_MemWrite), .ID_MemtoReg(ID_MemtoReg), .ID_RegWrite(ID_RegWrite),
    .ID_ALUOp(ID_ALUOp), .Flush(Flush),
    .IDEX_Valid(IDEX_Valid), .IDEX_RegRs(IDEX_RegRs), .IDEX_RegRt(IDEX_RegRt),
    .IDEX_RegRd(IDEX_RegRd), .IDEX_ReadData1(IDEX_ReadData1),
    .IDEX_ReadData2(IDEX_ReadData2), .IDEX_Imm(IDEX_Imm),
    .IDEX_RegDst(IDEX_RegDst), .IDEX_ALUSrc(IDEX_ALUSrc), .IDEX_MemRead(IDEX_MemRead),
    .IDEX_MemWrite(IDEX_MemWrite), .IDEX_MemtoReg(IDEX_MemtoReg),
    .IDEX_RegWrite(IDEX_RegWrite), .IDEX_ALUOp(IDEX_ALUOp),
    .Stall(Stall), .StallCount(StallCount)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input int rs, input int rt, input int rd,
                       input logic mr, input logic fl, input logic r);
    rst          = r;
    Flush        = fl;
    ID_Valid     = v;
    ID_RegRs     = 5'(rs);
    ID_RegRt     = 5'(rt);
    ID_RegRd     = 5'(rd);
    ID_ReadData1 = $urandom;
    ID_ReadData2 = $urandom;
    ID_Imm       = $urandom;
    ID_RegDst    = 1'($urandom);
    ID_ALUSrc    = 1'($urandom);
    ID_MemRead   = mr;
    ID_MemWrite  = 1'($urandom);
    ID_MemtoReg  = 1'($urandom);
    ID_RegWrite  = 1'($urandom);
    ID_ALUOp     = 4'($urandom);
  endtask

  // One clock: check Stall against the hazard rule, advance the model, check the register.
  task automatic cycle();
    logic [9:0] in_ctrl;
    #1;
    m_stall = !rst && !Flush && m_valid && m_ctrl[7] && (m_rt != 5'd0) && ID_Valid &&
              (m_rt == ID_RegRs || m_rt == ID_RegRt);
    check("stall", Stall, m_stall);
    in_ctrl = {ID_RegDst, ID_ALUSrc, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_RegWrite, ID_ALUOp};
    if (rst) begin
      m_cnt = 16'd0;
    end else if (m_stall && m_cnt != 16'hFFFF) begin
      m_cnt = m_cnt + 16'd1;
    end
    if (rst || Flush || m_stall || !ID_Valid) begin
      m_valid = 1'b0; m_rs = 5'd0; m_rt = 5'd0; m_rd = 5'd0;
      m_d1 = 32'd0; m_d2 = 32'd0; m_imm = 32'd0; m_ctrl = 10'd0;
    end else begin
      m_valid = 1'b1; m_rs = ID_RegRs; m_rt = ID_RegRt; m_rd = ID_RegRd;
      m_d1 = ID_ReadData1; m_d2 = ID_ReadData2; m_imm = ID_Imm; m_ctrl = in_ctrl;
    end
    @(posedge clk);
    #1;
    check("valid", IDEX_Valid, m_valid);
    check("regs", {IDEX_RegRs, IDEX_RegRt, IDEX_RegRd}, {m_rs, m_rt, m_rd});
    check("data1", IDEX_ReadData1, m_d1);
    check("data2", IDEX_ReadData2, m_d2);
    check("imm", IDEX_Imm, m_imm);
    check("ctrl", {IDEX_RegDst, IDEX_ALUSrc, IDEX_MemRead, IDEX_MemWrite, IDEX_MemtoReg,
                   IDEX_RegWrite, IDEX_ALUOp}, m_ctrl);
    check("count", StallCount, m_cnt);
    @(negedge clk);
  endtask

  initial begin
    m_valid = 1'b0; m_rs = '0; m_rt = '0; m_rd = '0;
    m_d1 = '0; m_d2 = '0; m_imm = '0; m_ctrl = '0; m_cnt = '0; m_stall = 1'b0;
    @(negedge clk);

    // Reset state
    drive(1, 1, 2, 3, 1, 0, 1); cycle();
    drive(1, 1, 2, 3, 1, 0, 1); cycle();
    check("rst_valid", IDEX_Valid, 1'b0);
    check("rst_count", StallCount, 16'd0);

    // lw $8 followed by a consumer of $8: one bubble, then the consumer goes through
    drive(1, 3, 8, 0, 1, 0, 0); cycle();
    drive(1, 8, 9, 10, 0, 0, 0);
    #1 check("lu_stall", Stall, 1'b1);
    cycle();
    check("lu_bubble", IDEX_Valid, 1'b0);
    check("lu_count", StallCount, 16'd1);
    cycle();
    check("lu_nostall", m_stall, 1'b0);
    check("lu_capture", {IDEX_Valid, IDEX_RegRs}, {1'b1, 5'd8});

    // Load into $0 never stalls
    drive(1, 4, 0, 0, 1, 0, 0); cycle();
    drive(1, 0, 6, 7, 0, 0, 0); cycle();
    check("r0_valid", IDEX_Valid, 1'b1);
    check("r0_count", StallCount, 16'd1);

    // Load-use hazard with a redirect: no stall, bubble, count unchanged
    drive(1, 3, 8, 0, 1, 0, 0); cycle();
    drive(1, 8, 9, 10, 0, 1, 0);
    #1 check("fl_stall", Stall, 1'b0);
    cycle();
    check("fl_bubble", IDEX_Valid, 1'b0);
    check("fl_count", StallCount, 16'd1);

    // Non-load producer never stalls
    drive(1, 1, 5, 2, 0, 0, 0); ID_RegWrite = 1'b1; cycle();
    drive(1, 2, 5, 3, 0, 0, 0); cycle();
    check("nl_capture", {IDEX_Valid, IDEX_RegRt}, {1'b1, 5'd5});

    // Reset in the stall cycle clears everything
    drive(1, 3, 8, 0, 1, 0, 0); cycle();
    drive(1, 8, 9, 10, 0, 0, 1); cycle();
    check("rs_count", StallCount, 16'd0);
    drive(1, 8, 9, 10, 0, 0, 0); cycle();
    check("rs_after", IDEX_Valid, 1'b1);

    // Saturation: preload near the top, then stall three times
    drive(0, 0, 0, 0, 0, 0, 0); cycle();
    drive(0, 0, 0, 0, 0, 0, 0);
    force dut.StallCount = 16'hFFFE;
    m_cnt = 16'hFFFE;
    cycle();
    release dut.StallCount;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 12, 0, 1, 0, 0); cycle();
      drive(1, 12, 2, 3, 0, 0, 0); cycle();
      check("sat_count", StallCount, (i == 0) ? 16'hFFFF : 16'hFFFF);
    end

    // Randomized traffic with a narrow register range to provoke hazards
    drive(0, 0, 0, 0, 0, 0, 1); cycle();
    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(0, 9) != 0), $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 31), ($urandom_range(0, 1) == 1),
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 49) == 0));
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
